user_io_ctrl: RTL and testbench

- Wishbone-slave controller for the user-area GPIO pads (io_out / io_oeb / io_in).
- CPU-programmable output data and output-enable registers.
- io_in is double-flop synchronised and readable.
- Per-pin rising-edge detection raises a maskable, sticky, write-1-to-clear interrupt on user_irq[0].
- Sits inside user_project between the Wishbone MI A port and the pad bus.

---
 rtl/user_io_ctrl_if.sv | 31 +++
 rtl/user_io_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_user_io_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/user_io_ctrl_if.sv
// ----------------------------------------------------------------------------
// user_io_ctrl_if
// Wishbone slave bus bundle for user_io_ctrl (classic single-beat accesses).
//   wbs_stb_i / wbs_cyc_i : strobe / cycle from the master
//   wbs_we_i              : 1 = write, 0 = read
//   wbs_sel_i[3:0]        : byte lane enables
//   wbs_adr_i[31:0]       : byte address
//   wbs_dat_i[31:0]       : write data
//   wbs_ack_o             : single-cycle acknowledge from the slave
//   wbs_dat_o[31:0]       : read data from the slave
// ----------------------------------------------------------------------------
interface user_io_ctrl_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/user_io_ctrl.sv
// ----------------------------------------------------------------------------
// user_io_ctrl
// Wishbone-slave controller for the user-area GPIO pads. Holds the pad output
// data (OUT) and active-low output enables (OEB), synchronises io_in through
// two flops, and flags rising edges per pin in a sticky W1C status register
// that drives user_irq[0] when enabled.
//
// Ports:
//   wb_clk_i        sole clock, rising edge
//   wb_rst_i        synchronous active-high reset
//   wbs             Wishbone slave bundle (user_io_ctrl_if.slave)
//   io_in[NPINS]    asynchronous pad inputs
//   io_out[NPINS]   pad output data      (= OUT register)
//   io_oeb[NPINS]   pad output enables   (= OEB register, 0 drives the pad)
//   user_irq[2:0]   [0] edge interrupt, [2:1] always 0
//
// Register map (word offset from wbs_adr_i[7:0], LO = bits 31:0, HI = NPINS-1:32):
//   0x00/0x04 OUT  RW   0x08/0x0C OEB RW   0x10/0x14 IN RO
//   0x18/0x1C IRQ_EN RW 0x20/0x24 IRQ_STAT W1C   everything else reads 0
//
// Build option: define USER_IO_CTRL_LOOPBACK_EN to add LOOPBACK (offset 0x28
// bit 0); when set, driven pins feed their own OUT value into the synchroniser.
// ----------------------------------------------------------------------------
module user_io_ctrl #(
  parameter int          NPINS    = 38,
  parameter logic [31:0] ADR_BASE = 32'h3000_0000
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  user_io_ctrl_if.slave    wbs,
  input  logic [NPINS-1:0] io_in,
  output logic [NPINS-1:0] io_out,
  output logic [NPINS-1:0] io_oeb,
  output logic [2:0]       user_irq
);

  // Expand byte selects into a 32-bit lane mask.
  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

  // Place a 32-bit lane mask onto the LO or HI half of an NPINS-wide register.
  function automatic logic [NPINS-1:0] lane_mask(input logic hi, input logic [31:0] bm);
    logic [NPINS-1:0] m;
    for (int i = 0; i < NPINS; i++) begin
      m[i] = bm[i % 32] & (hi == (i >= 32));
    end
    return m;
  endfunction

  // Replicate the 32-bit bus word across the register width.
  function automatic logic [NPINS-1:0] lane_data(input logic [31:0] d);
    logic [NPINS-1:0] v;
    for (int i = 0; i < NPINS; i++) begin
      v[i] = d[i % 32];
    end
    return v;
  endfunction

  // Return the LO or HI word of a register; unimplemented HI bits read 0.
  function automatic logic [31:0] read_word(input logic hi, input logic [NPINS-1:0] r);
    logic [63:0] w;
    w = 64'(r);
    return hi ? w[63:32] : w[31:0];
  endfunction

  logic [NPINS-1:0] out_q, out_d, oeb_q, oeb_d, en_q, en_d, stat_q, stat_d;
  logic [NPINS-1:0] s1_q, s1_d, s2_q, s2_d, prev_q, prev_d;
  logic             ack_q, ack_d, irq_q, irq_d;
  logic [31:0]      dat_q, dat_d;
`ifdef USER_IO_CTRL_LOOPBACK_EN
  logic             lb_q, lb_d;
`endif

  logic             req_s, wr_s, hi_s;
  logic [NPINS-1:0] mask_s, wdat_s, clr_s, rise_s, sync_in_s;
  logic [31:0]      rd_s;
  logic             unused_adr_s;

  assign unused_adr_s = ^wbs.wbs_adr_i[1:0];

  // Next-state logic: bus decode, register writes, read mux and edge detection.
  always_comb begin
    req_s  = wbs.wbs_stb_i & wbs.wbs_cyc_i &
             (wbs.wbs_adr_i[31:8] == ADR_BASE[31:8]);
    // Ack is a one-cycle pulse; it self-clears so back-to-back accesses see a gap.
    ack_d  = req_s & ~ack_q;
    wr_s   = ack_d & wbs.wbs_we_i;
    hi_s   = wbs.wbs_adr_i[2];
    mask_s = lane_mask(hi_s, byte_mask(wbs.wbs_sel_i));
    wdat_s = lane_data(wbs.wbs_dat_i);

    out_d  = out_q;
    oeb_d  = oeb_q;
    en_d   = en_q;
    clr_s  = {NPINS{1'b0}};
    rd_s   = 32'h0000_0000;
`ifdef USER_IO_CTRL_LOOPBACK_EN
    lb_d   = lb_q;
`endif

    case (wbs.wbs_adr_i[7:3])
      5'd0: begin
        rd_s = read_word(hi_s, out_q);
        if (wr_s) out_d = (out_q & ~mask_s) | (wdat_s & mask_s);
        else      out_d = out_q;
      end
      5'd1: begin
        rd_s = read_word(hi_s, oeb_q);
        if (wr_s) oeb_d = (oeb_q & ~mask_s) | (wdat_s & mask_s);
        else      oeb_d = oeb_q;
      end
      5'd2: begin
        rd_s = read_word(hi_s, s2_q);
      end
      5'd3: begin
        rd_s = read_word(hi_s, en_q);
        if (wr_s) en_d = (en_q & ~mask_s) | (wdat_s & mask_s);
        else      en_d = en_q;
      end
      5'd4: begin
        rd_s = read_word(hi_s, stat_q);
        if (wr_s) clr_s = wdat_s & mask_s;
        else      clr_s = {NPINS{1'b0}};
      end
`ifdef USER_IO_CTRL_LOOPBACK_EN
      5'd5: begin
        if (hi_s) begin
          rd_s = 32'h0000_0000;
          lb_d = lb_q;
        end else begin
          rd_s = {31'h0000_0000, lb_q};
          if (wr_s && wbs.wbs_sel_i[0]) lb_d = wbs.wbs_dat_i[0];
          else                          lb_d = lb_q;
        end
      end
`endif
      default: begin
        rd_s = 32'h0000_0000;
      end
    endcase

    // Read data is captured on the edge ack rises and held otherwise.
    if (ack_d) dat_d = rd_s;
    else       dat_d = dat_q;

`ifdef USER_IO_CTRL_LOOPBACK_EN
    // Driven pins (OEB = 0) observe their own output data.
    if (lb_q) sync_in_s = (out_q & ~oeb_q) | (io_in & oeb_q);
    else      sync_in_s = io_in;
`else
    sync_in_s = io_in;
`endif
    s1_d   = sync_in_s;
    s2_d   = s1_q;
    prev_d = s2_q;
    rise_s = s2_q & ~prev_q;
    // Set after clear so a new edge wins over a same-cycle W1C.
    stat_d = (stat_q & ~clr_s) | rise_s;
    irq_d  = |(stat_q & en_q);
  end

  // State registers with synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      out_q  <= {NPINS{1'b0}};
      oeb_q  <= {NPINS{1'b1}};
      en_q   <= {NPINS{1'b0}};
      stat_q <= {NPINS{1'b0}};
      s1_q   <= {NPINS{1'b0}};
      s2_q   <= {NPINS{1'b0}};
      prev_q <= {NPINS{1'b0}};
      ack_q  <= 1'b0;
      dat_q  <= 32'h0000_0000;
      irq_q  <= 1'b0;
`ifdef USER_IO_CTRL_LOOPBACK_EN
      lb_q   <= 1'b0;
`endif
    end else begin
      out_q  <= out_d;
      oeb_q  <= oeb_d;
      en_q   <= en_d;
      stat_q <= stat_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
      ack_q  <= ack_d;
      dat_q  <= dat_d;
      irq_q  <= irq_d;
`ifdef USER_IO_CTRL_LOOPBACK_EN
      lb_q   <= lb_d;
`endif
    end
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;
  assign io_out        = out_q;
  assign io_oeb        = oeb_q;
  assign user_irq      = {2'b00, irq_q};

endmodule

// File: tb/tb_user_io_ctrl.sv
// ----------------------------------------------------------------------------
// tb_user_io_ctrl
// Self-checking bench for user_io_ctrl. Read expectations go into a queue when
// the access is issued and are compared when the DUT acknowledges it.
// ----------------------------------------------------------------------------
module tb_user_io_ctrl;
  localparam int NPINS = 38;

  logic             wb_clk_i = 1'b0;
  logic             wb_rst_i;
  logic [NPINS-1:0] io_in;
  logic [NPINS-1:0] io_out;
  logic [NPINS-1:0] io_oeb;
  logic [2:0]       user_irq;

  user_io_ctrl_if wb_if ();

  user_io_ctrl #(.NPINS(NPINS), .ADR_BASE(32'h3000_0000)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .wbs      (wb_if),
    .io_in    (io_in),
    .io_out   (io_out),
    .io_oeb   (io_oeb),
    .user_irq (user_irq)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic [31:0] exp;
    logic [31:0] mask;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Single access, started at a negedge; returns at a negedge.
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat, output logic acked, output logic [31:0] rdat);
    acked = 1'b0;
    rdat  = 32'h0;
    wb_if.wbs_stb_i = 1'b1;
    wb_if.wbs_cyc_i = 1'b1;
    wb_if.wbs_we_i  = we;
    wb_if.wbs_sel_i = sel;
    wb_if.wbs_adr_i = adr;
    wb_if.wbs_dat_i = dat;
    for (int n = 0; n < 8; n++) begin
      @(negedge wb_clk_i);
      if (wb_if.wbs_ack_o) begin
        acked = 1'b1;
        rdat  = wb_if.wbs_dat_o;
        break;
      end
    end
    wb_if.wbs_stb_i = 1'b0;
    wb_if.wbs_cyc_i = 1'b0;
    wb_if.wbs_we_i  = 1'b0;
    if (acked) begin
      @(negedge wb_clk_i);
      check("ack_one_cycle", 64'(wb_if.wbs_ack_o), 64'd0);
    end
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
    logic        acked;
    logic [31:0] rdat;
    wb_xfer(1'b1, adr, sel, dat, acked, rdat);
    check("write_ack", 64'(acked), 64'd1);
  endtask

  task automatic wb_read(input string tag, input logic [31:0] adr,
                         input logic [31:0] exp, input logic [31:0] mask);
    logic        acked;
    logic [31:0] rdat;
    exp_t        e;
    sb_q.push_back('{exp: exp, mask: mask, tag: tag});
    wb_xfer(1'b0, adr, 4'hF, 32'h0, acked, rdat);
    check("read_ack", 64'(acked), 64'd1);
    e = sb_q.pop_front();
    if (acked) check(e.tag, 64'(rdat & e.mask), 64'(e.exp & e.mask));
    else       check({e.tag, "_noack"}, 64'(acked), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        acked;
    logic [31:0] rdat;

    wb_rst_i        = 1'b1;
    io_in           = '0;
    wb_if.wbs_stb_i = 1'b0;
    wb_if.wbs_cyc_i = 1'b0;
    wb_if.wbs_we_i  = 1'b0;
    wb_if.wbs_sel_i = 4'h0;
    wb_if.wbs_adr_i = 32'h0;
    wb_if.wbs_dat_i = 32'h0;
    repeat (2) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;

    // Reset state
    check("rst_io_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
    check("rst_io_out", 64'(io_out), 64'h0);
    check("rst_irq", 64'(user_irq), 64'h0);
    check("rst_ack", 64'(wb_if.wbs_ack_o), 64'h0);
    check("rst_dat", 64'(wb_if.wbs_dat_o), 64'h0);
    wb_read("rst_out_lo",  32'h3000_0000, 32'h0000_0000, 32'hFFFF_FFFF);
    wb_read("rst_oeb_lo",  32'h3000_0008, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wb_read("rst_oeb_hi",  32'h3000_000C, 32'h0000_003F, 32'hFFFF_FFFF);
    wb_read("rst_en_lo",   32'h3000_0018, 32'h0000_0000, 32'hFFFF_FFFF);
    wb_read("rst_stat_lo", 32'h3000_0020, 32'h0000_0000, 32'hFFFF_FFFF);

    // Byte-lane gated write to OUT
    wb_write(32'h3000_0000, 4'b0011, 32'hA5A5_5A5A);
    check("out_pads_lo", 64'(io_out), 64'h00_0000_5A5A);
    wb_read("out_lo_sel", 32'h3000_0000, 32'h0000_5A5A, 32'hFFFF_FFFF);
    wb_write(32'h3000_0004, 4'b1111, 32'hFFFF_FFFF);
    check("out_pads_hi", 64'(io_out), 64'h3F_0000_5A5A);
    wb_read("out_hi_trunc", 32'h3000_0004, 32'h0000_003F, 32'hFFFF_FFFF);

    // OEB HI half
    wb_write(32'h3000_000C, 4'b1111, 32'h0000_0000);
    check("oeb_pads_hi0", 64'(io_oeb), 64'h00_FFFF_FFFF);
    wb_read("oeb_hi_zero", 32'h3000_000C, 32'h0000_0000, 32'hFFFF_FFFF);
    wb_write(32'h3000_000C, 4'b1111, 32'hFFFF_FFFF);
    wb_read("oeb_hi_trunc", 32'h3000_000C, 32'h0000_003F, 32'hFFFF_FFFF);
    check("oeb_pads_hi1", 64'(io_oeb), 64'h3F_FFFF_FFFF);

    // Input synchroniser readback; writes to IN are ignored
    io_in = 38'h2A_1234_5678;
    repeat (3) @(negedge wb_clk_i);
    wb_write(32'h3000_0010, 4'b1111, 32'h0000_0000);
    wb_read("in_lo", 32'h3000_0010, 32'h1234_5678, 32'hFFFF_FFFF);
    wb_read("in_hi", 32'h3000_0014, 32'h0000_002A, 32'hFFFF_FFFF);

    // Quiesce inputs and clear all status
    io_in = '0;
    repeat (4) @(negedge wb_clk_i);
    wb_write(32'h3000_0020, 4'b1111, 32'hFFFF_FFFF);
    wb_write(32'h3000_0024, 4'b1111, 32'hFFFF_FFFF);
    wb_read("stat_cleared_lo", 32'h3000_0020, 32'h0000_0000, 32'hFFFF_FFFF);
    wb_read("stat_cleared_hi", 32'h3000_0024, 32'h0000_0000, 32'hFFFF_FFFF);

    // Edge interrupt timing on pin 0
    wb_write(32'h3000_0018, 4'b1111, 32'h0000_0001);
    wb_read("en_lo", 32'h3000_0018, 32'h0000_0001, 32'hFFFF_FFFF);
    check("irq_idle", 64'(user_irq), 64'h0);
    io_in[0] = 1'b1;
    repeat (3) @(negedge wb_clk_i);
    check("irq_t3_low", 64'(user_irq), 64'h0);
    @(negedge wb_clk_i);
    check("irq_t4_high", 64'(user_irq), 64'h1);
    wb_read("stat_bit0_set", 32'h3000_0020, 32'h0000_0001, 32'h0000_0001);
    check("irq_held", 64'(user_irq), 64'h1);
    wb_write(32'h3000_0020, 4'b0001, 32'h0000_0001);
    check("irq_cleared", 64'(user_irq), 64'h0);
    wb_read("stat_bit0_clr", 32'h3000_0020, 32'h0000_0000, 32'h0000_0001);

    // W1C under an inactive byte lane has no effect on that lane
    io_in[0] = 1'b0;
    repeat (4) @(negedge wb_clk_i);
    io_in[0] = 1'b1;
    repeat (5) @(negedge wb_clk_i);
    wb_write(32'h3000_0020, 4'b1110, 32'hFFFF_FFFF);
    wb_read("w1c_sel_gated", 32'h3000_0020, 32'h0000_0001, 32'h0000_0001);
    wb_write(32'h3000_0020, 4'b0001, 32'h0000_0001);

    // Same-edge set and clear: the new edge wins
    io_in[0] = 1'b0;
    repeat (4) @(negedge wb_clk_i);
    wb_read("stat_pre_race", 32'h3000_0020, 32'h0000_0000, 32'h0000_0001);
    io_in[0] = 1'b1;
    repeat (2) @(negedge wb_clk_i);
    wb_write(32'h3000_0020, 4'b0001, 32'h0000_0001);
    wb_read("stat_set_wins", 32'h3000_0020, 32'h0000_0001, 32'h0000_0001);
    check("irq_after_race", 64'(user_irq), 64'h1);
    wb_write(32'h3000_0020, 4'b0001, 32'h0000_0001);
    @(negedge wb_clk_i);
    check("irq_race_cleared", 64'(user_irq), 64'h0);

    // Address outside the block is never acknowledged
    wb_xfer(1'b0, 32'h3000_1000, 4'hF, 32'h0, acked, rdat);
    check("no_match_ack", 64'(acked), 64'h0);
    wb_xfer(1'b1, 32'h3000_1000, 4'hF, 32'h0, acked, rdat);
    check("no_match_ack_wr", 64'(acked), 64'h0);
    check("no_match_out", 64'(io_out), 64'h3F_0000_5A5A);

    // Unimplemented offsets read 0
    wb_write(32'h3000_00FC, 4'hF, 32'hFFFF_FFFF);
    wb_read("unimpl_fc", 32'h3000_00FC, 32'h0000_0000, 32'hFFFF_FFFF);
    wb_read("unimpl_2c", 32'h3000_002C, 32'h0000_0000, 32'hFFFF_FFFF);

`ifdef USER_IO_CTRL_LOOPBACK_EN
    io_in = '0;
    repeat (4) @(negedge wb_clk_i);
    wb_write(32'h3000_0008, 4'hF, 32'hFFFF_FFFF);
    wb_write(32'h3000_0000, 4'hF, 32'h0000_0008);
    wb_write(32'h3000_0020, 4'hF, 32'hFFFF_FFFF);
    wb_write(32'h3000_0028, 4'hF, 32'h0000_0001);
    wb_read("lb_reg", 32'h3000_0028, 32'h0000_0001, 32'hFFFF_FFFF);
    wb_write(32'h3000_0008, 4'hF, 32'hFFFF_FFF7);
    repeat (4) @(negedge wb_clk_i);
    wb_read("lb_in_bit3", 32'h3000_0010, 32'h0000_0008, 32'h0000_0008);
    wb_read("lb_stat_bit3", 32'h3000_0020, 32'h0000_0008, 32'h0000_0008);
`else
    wb_write(32'h3000_0028, 4'hF, 32'h0000_0001);
    wb_read("unimpl_28", 32'h3000_0028, 32'h0000_0000, 32'hFFFF_FFFF);
`endif

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    check("irq_upper_zero", 64'(user_irq[2:1]), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
